// File: rtl/xc_rf_wport_arb_if.sv
// ---------------------------------------------------------------------------
// xc_rf_wport_arb_if
//   Bundles the signals between the GPR write-port arbiter and its clients:
//   the two writeback request ports, the coprocessor destination-allocation
//   strobe, the register file write port, the pending-write scoreboard and
//   the init-done flag.
//
//   Signals:
//     p0_valid/p0_ready/p0_addr/p0_wdata  main pipeline writeback handshake
//     p1_valid/p1_ready/p1_addr/p1_wdata  crypto coprocessor writeback handshake
//     p1_alloc/p1_alloc_addr              coprocessor destination allocation
//     rd_wen/rd_addr/rd_wdata             register file write port
//     busy                                pending coprocessor destinations
//     init_done                           register file contents defined
//
//   Modports:
//     master  requesters / register file side (drives requests)
//     slave   the arbiter (drives readies, write port, scoreboard)
// ---------------------------------------------------------------------------
interface xc_rf_wport_arb_if;
    logic        p0_valid;
    logic        p0_ready;
    logic [4:0]  p0_addr;
    logic [31:0] p0_wdata;

    logic        p1_valid;
    logic        p1_ready;
    logic [4:0]  p1_addr;
    logic [31:0] p1_wdata;

    logic        p1_alloc;
    logic [4:0]  p1_alloc_addr;

    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;

    logic [31:0] busy;
    logic        init_done;

    modport master (
        output p0_valid, p0_addr, p0_wdata,
        output p1_valid, p1_addr, p1_wdata,
        output p1_alloc, p1_alloc_addr,
        input  p0_ready, p1_ready,
        input  rd_wen, rd_addr, rd_wdata,
        input  busy, init_done
    );

    modport slave (
        input  p0_valid, p0_addr, p0_wdata,
        input  p1_valid, p1_addr, p1_wdata,
        input  p1_alloc, p1_alloc_addr,
        output p0_ready, p1_ready,
        output rd_wen, rd_addr, rd_wdata,
        output busy, init_done
    );
endinterface

// File: rtl/xc_rf_wport_arb.sv
// ---------------------------------------------------------------------------
// xc_rf_wport_arb
//   Shares the single write port of the 2R/1W GPR file between the main
//   pipeline writeback (port 0) and the crypto coprocessor writeback
//   (port 1). Port 0 has fixed priority; a starvation counter hands priority
//   to port 1 after it has been refused STARVE_LIM consecutive cycles.
//   A scoreboard records coprocessor destinations that are allocated but not
//   yet written back so issue logic can detect hazards.
//
//   Optional feature, macro XC_RF_INIT_EN: after every reset the block spends
//   31 cycles writing zero to x1..x31 (the register file has no reset), with
//   both readies held low, then enters RUN and raises init_done. Without the
//   macro the block resets straight into RUN with init_done = 1.
//
//   Parameters:
//     STARVE_LIM  refusals of a valid port-1 request before it wins (1..15)
//
//   Ports:
//     i_clock   clock, all state updates on posedge
//     i_resetn  asynchronous active-low reset
//     io_wp     xc_rf_wport_arb_if.slave (requests, write port, scoreboard)
// ---------------------------------------------------------------------------
module xc_rf_wport_arb #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic               i_clock,
    input  logic               i_resetn,
    xc_rf_wport_arb_if.slave   io_wp
);

    localparam logic [3:0] LIM = STARVE_LIM[3:0];

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      w_state;
    logic        w_init_wen;
    logic [4:0]  w_init_addr;

    logic [3:0]  r_starve_cnt;
    logic [31:0] r_busy;

    logic        w_run;
    logic        w_starved;
    logic        w_p0_ready;
    logic        w_p1_ready;
    logic        w_p0_fire;
    logic        w_p1_fire;

    logic        w_rd_wen;
    logic [4:0]  w_rd_addr;
    logic [31:0] w_rd_wdata;

    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

`ifdef XC_RF_INIT_EN
    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_init_cnt;
    logic [4:0]  w_init_cnt_nxt;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 5'd1;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // INIT walks x1..x31 writing zero; the transition happens on the x31
    // write, so RUN begins exactly 31 cycles after reset release.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_init_wen     = 1'b0;
        w_init_addr    = 5'd0;
        case (r_state)
            ST_INIT: begin
                w_init_wen     = 1'b1;
                w_init_addr    = r_init_cnt;
                w_init_cnt_nxt = r_init_cnt + 5'd1;
                if (r_init_cnt == 5'd31) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_state = r_state;
`else
    assign w_state     = ST_RUN;
    assign w_init_wen  = 1'b0;
    assign w_init_addr = 5'd0;
`endif

    assign w_run     = (w_state == ST_RUN);
    assign w_starved = (r_starve_cnt == LIM);

    // Port 0 wins unless port 1 is starved and asking; the two grants are
    // mutually exclusive, so at most one port fires per cycle.
    assign w_p0_ready = w_run && !(io_wp.p1_valid && w_starved);
    assign w_p1_ready = w_run && (!io_wp.p0_valid || w_starved);

    assign w_p0_fire = io_wp.p0_valid && w_p0_ready;
    assign w_p1_fire = io_wp.p1_valid && w_p1_ready;

    // Write-port mux. A write to x0 still completes the handshake but never
    // reaches the register file.
    always_comb begin
        w_rd_wen   = 1'b0;
        w_rd_addr  = 5'd0;
        w_rd_wdata = 32'd0;
        if (w_init_wen) begin
            w_rd_wen  = 1'b1;
            w_rd_addr = w_init_addr;
        end else if (w_p0_fire) begin
            w_rd_wen   = (io_wp.p0_addr != 5'd0);
            w_rd_addr  = io_wp.p0_addr;
            w_rd_wdata = io_wp.p0_wdata;
        end else if (w_p1_fire) begin
            w_rd_wen   = (io_wp.p1_addr != 5'd0);
            w_rd_addr  = io_wp.p1_addr;
            w_rd_wdata = io_wp.p1_wdata;
        end
    end

    // Counts consecutive refusals of a valid port-1 request, saturating at
    // the limit; any cycle without a pending refused request clears it.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_starve_cnt <= 4'd0;
        end else if (io_wp.p1_valid && !w_p1_ready) begin
            if (r_starve_cnt != LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    // Set has priority over clear so an allocation colliding with the
    // commit of an older instruction to the same register stays pending.
    // x0 is never marked: it cannot hold a hazard.
    always_comb begin
        w_busy_set = 32'd0;
        w_busy_clr = 32'd0;
        if (io_wp.p1_alloc && (io_wp.p1_alloc_addr != 5'd0)) begin
            w_busy_set[io_wp.p1_alloc_addr] = 1'b1;
        end
        if (w_p1_fire) begin
            w_busy_clr[io_wp.p1_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign io_wp.p0_ready  = w_p0_ready;
    assign io_wp.p1_ready  = w_p1_ready;
    assign io_wp.rd_wen    = w_rd_wen;
    assign io_wp.rd_addr   = w_rd_addr;
    assign io_wp.rd_wdata  = w_rd_wdata;
    assign io_wp.busy      = r_busy;
    assign io_wp.init_done = w_run;

endmodule

// File: tb/tb_xc_rf_wport_arb.sv
// ---------------------------------------------------------------------------
// tb_xc_rf_wport_arb
//   Self-checking bench for xc_rf_wport_arb (works with or without
//   XC_RF_INIT_EN). A behavioural model tracks remaining init cycles, how
//   long port 1 has been kept waiting, and the set of pending coprocessor
//   destinations; every cycle the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_xc_rf_wport_arb;

    localparam int LIM = 4;

    logic clk;
    logic resetn;

    xc_rf_wport_arb_if wp();

    xc_rf_wport_arb #(.STARVE_LIM(LIM)) dut (
        .i_clock  (clk),
        .i_resetn (resetn),
        .io_wp    (wp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference state
    int          m_init_left;   // register-file zeroing cycles still to go
    int          m_wait;        // cycles port 1 has asked and been refused
    logic [31:0] m_busy;        // pending coprocessor destinations

    // What the DUT showed in the most recent step
    logic        last_p0r, last_p1r, last_wen;
    logic [4:0]  last_addr;
    logic [31:0] last_data, last_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
`ifdef XC_RF_INIT_EN
        m_init_left = 31;
`else
        m_init_left = 0;
`endif
        m_wait = 0;
        m_busy = 32'd0;
    endtask

    task automatic drive_idle();
        wp.p0_valid = 1'b0; wp.p0_addr = 5'd0; wp.p0_wdata = 32'd0;
        wp.p1_valid = 1'b0; wp.p1_addr = 5'd0; wp.p1_wdata = 32'd0;
        wp.p1_alloc = 1'b0; wp.p1_alloc_addr = 5'd0;
    endtask

    // Asserts reset between clock edges, checks the reset-time outputs,
    // holds it for two rising edges and releases it on a falling edge.
    task automatic apply_reset();
        #2;
        drive_idle();
        resetn = 1'b0;
        model_reset();
        #1;
        check("rst_busy", wp.busy, 32'd0);
        check("rst_init_done", {31'd0, wp.init_done}, {31'd0, m_init_left == 0});
        check("rst_wen", {31'd0, wp.rd_wen}, {31'd0, m_init_left != 0});
        check("rst_p0_ready", {31'd0, wp.p0_ready}, 32'd0 + (m_init_left == 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // One clock cycle: drive inputs just after a falling edge, compare the
    // combinational outputs against the model, advance the model, and end
    // on the next falling edge.
    task automatic step(input logic p0v, input logic [4:0] p0a, input logic [31:0] p0d,
                        input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d,
                        input logic al, input logic [4:0] ala);
        logic        in_init, p1_urgent, e_r0, e_r1, f0, f1, e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        wp.p0_valid = p0v; wp.p0_addr = p0a; wp.p0_wdata = p0d;
        wp.p1_valid = p1v; wp.p1_addr = p1a; wp.p1_wdata = p1d;
        wp.p1_alloc = al;  wp.p1_alloc_addr = ala;
        #1;
        in_init   = (m_init_left > 0);
        p1_urgent = p1v && (m_wait >= LIM);
        // Grant policy: nobody during init; otherwise a port 1 that has waited
        // long enough wins, else port 0 wins, else port 1 takes the slot.
        if (in_init) begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
        end else begin
            e_r0 = !p1_urgent;
            e_r1 = p1_urgent || !p0v;
        end
        f0 = p0v && e_r0;
        f1 = p1v && e_r1;
        e_wen = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        if (in_init) begin
            e_wen  = 1'b1;
            e_addr = 5'(32 - m_init_left);
        end else if (f0) begin
            e_wen = (p0a != 5'd0); e_addr = p0a; e_data = p0d;
        end else if (f1) begin
            e_wen = (p1a != 5'd0); e_addr = p1a; e_data = p1d;
        end
        check("p0_ready", {31'd0, wp.p0_ready}, {31'd0, e_r0});
        check("p1_ready", {31'd0, wp.p1_ready}, {31'd0, e_r1});
        check("rd_wen", {31'd0, wp.rd_wen}, {31'd0, e_wen});
        check("rd_addr", {27'd0, wp.rd_addr}, {27'd0, e_addr});
        check("rd_wdata", wp.rd_wdata, e_data);
        check("busy", wp.busy, m_busy);
        check("init_done", {31'd0, wp.init_done}, {31'd0, !in_init});
        last_p0r = wp.p0_ready; last_p1r = wp.p1_ready; last_wen = wp.rd_wen;
        last_addr = wp.rd_addr; last_data = wp.rd_wdata; last_busy = wp.busy;
        if (in_init) m_init_left--;
        if (p1v && !f1) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
        else            m_wait = 0;
        if (f1) m_busy[p1a] = 1'b0;
        if (al && ala != 5'd0) m_busy[ala] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    logic        h0v, h1v, hal;
    logic [4:0]  h0a, h1a, hala;
    logic [31:0] h0d, h1d;

    initial begin
        resetn = 1'b0;
        drive_idle();
        last_p0r = 1'b0; last_p1r = 1'b0; last_wen = 1'b0;
        last_addr = 5'd0; last_data = 32'd0; last_busy = 32'd0;
        apply_reset();

        // Disturb scoreboard and starvation state, then reset mid-sequence.
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        for (int i = 0; i < 8; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0);
        apply_reset();
        idle_step();
        check("rst_restart_busy", last_busy, 32'd0);
`ifdef XC_RF_INIT_EN
        check("rst_restart_addr", {27'd0, last_addr}, 32'd1);
`endif

        // Finish the zeroing sequence, then the first RUN cycle takes a write.
        while (m_init_left > 0) idle_step();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("first_run_p0_ready", {31'd0, last_p0r}, 32'd1);
        check("first_run_addr", {27'd0, last_addr}, 32'd5);
        check("first_run_data", last_data, 32'hDEADBEEF);

        // Both ports continuously valid: port 1 wins every LIM+1 cycles.
        idle_step();
        for (int i = 0; i < 3 * (LIM + 1); i++) begin
            step(1'b1, 5'd2, 32'hA0 + i, 1'b1, 5'd6, 32'hC0C0, 1'b0, 5'd0);
            check("starve_p1_grant", {31'd0, last_p1r}, {31'd0, (i % (LIM + 1)) == LIM});
        end

        // Scoreboard: allocate x7, commit it three cycles later.
        idle_step();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        idle_step();
        check("alloc_busy7", {31'd0, last_busy[7]}, 32'd1);
        idle_step();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
        check("commit7_wen", {31'd0, last_wen}, 32'd1);
        idle_step();
        check("commit7_busy", {31'd0, last_busy[7]}, 32'd0);

        // Same-cycle alloc and commit to an already pending register.
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        check("alloc_commit_busy9", {31'd0, last_busy[9]}, 32'd1);
        idle_step();
        check("alloc_x0_busy0", {31'd0, last_busy[0]}, 32'd0);

        // x0 write from port 0, then port 1 alone.
        step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("x0_p0_ready", {31'd0, last_p0r}, 32'd1);
        check("x0_wen", {31'd0, last_wen}, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0);
        check("p1_alone_ready", {31'd0, last_p1r}, 32'd1);

        // Randomized traffic honoring the hold-while-stalled rule.
        h0v = 1'b0; h1v = 1'b0; h0a = 5'd0; h1a = 5'd0; h0d = 32'd0; h1d = 32'd0;
        for (int i = 0; i < 2000; i++) begin
            if (!(h0v && !last_p0r)) begin
                h0v = ($urandom_range(0, 9) < 6);
                h0a = 5'($urandom_range(0, 31));
                h0d = $urandom;
            end
            if (!(h1v && !last_p1r)) begin
                h1v = ($urandom_range(0, 9) < 5);
                h1a = 5'($urandom_range(0, 31));
                h1d = $urandom;
            end
            hal  = ($urandom_range(0, 3) == 0);
            hala = 5'($urandom_range(0, 31));
            step(h0v, h0a, h0d, h1v, h1a, h1d, hal, hala);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/xc_rf_wport_arb.md
# xc_rf_wport_arb

Write-port arbiter and scheduler for the 2-read/1-write GPR file. It shares the single write port between the main-pipeline writeback (port 0) and the multi-cycle crypto coprocessor writeback (port 1), using fixed priority with a starvation guard. It keeps a pending-write scoreboard for coprocessor destinations so issue logic can detect hazards. Optionally, it sequences zero-initialisation of x1..x31 after reset, because the register file itself has no reset.

## Interface
Parameters:
- STARVE_LIM, default 4: consecutive cycles port 1 may be valid-but-refused before it takes priority; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- p0_valid  in  1  pipeline writeback request.
- p0_ready  out  1  pipeline request accepted this cycle.
- p0_addr  in  5  pipeline destination register.
- p0_wdata  in  32  pipeline write data.
- p1_valid  in  1  coprocessor writeback request.
- p1_ready  out  1  coprocessor request accepted this cycle.
- p1_addr  in  5  coprocessor destination register.
- p1_wdata  in  32  coprocessor write data.
- p1_alloc  in  1  coprocessor instruction issued; mark its destination pending.
- p1_alloc_addr  in  5  destination register being allocated.
- rd_wen  out  1  register file write enable.
- rd_addr  out  5  register file write address.
- rd_wdata  out  32  register file write data.
- busy  out  32  pending coprocessor destinations, one bit per register; bit 0 is always 0.
- init_done  out  1  arbiter in RUN state and register file contents defined.

## Operation
- States: INIT (only when the macro is defined) and RUN.
- A transfer on port N fires when pN_valid && pN_ready.
- Ports hold addr/wdata stable while valid and not ready.
- Arbitration in RUN:
  - starved = (starve_cnt == STARVE_LIM).
  - p0_ready = !(p1_valid && starved).
  - p1_ready = !p0_valid || starved.
  - Both ready signals are 0 in INIT.
- starve_cnt, width 4 bits:
  - Increments (saturating at STARVE_LIM) each cycle p1_valid && !p1_ready.
  - Clears when p1 fires or when p1_valid is 0.
- Write port (combinational from the winning port):
  - rd_wen = fire && (addr != 0).
  - rd_addr and rd_wdata come from the fired port.
  - When idle, rd_wen = 0 and rd_addr/rd_wdata = 0.
  - Writes to x0 are accepted (ready handshake completes) but rd_wen is suppressed.
- Scoreboard:
  - busy[a] is set on p1_alloc with p1_alloc_addr = a, for a != 0.
  - busy[a] is cleared when p1 fires with p1_addr = a.
  - Same-cycle alloc and commit to the same register: set wins, so the bit stays 1.
  - Alloc to a register that is already busy: no change.
  - A p0 write never touches busy.
- INIT sequence (macro defined):
  - init_cnt starts at 1 on reset.
  - Each cycle: rd_wen = 1, rd_addr = init_cnt, rd_wdata = 0, then init_cnt increments.
  - After writing x31 the FSM moves to RUN and init_done rises.
  - p1_alloc is still recorded during INIT.

## Timing
- Reset values:
  - With the macro: init_done = 0, state INIT, init_cnt = 1.
  - Without the macro: init_done = 1, state RUN.
  - In both cases: starve_cnt = 0 and busy = 0.
  - rd_wen is 1 from the first clock of INIT, or 0 when idle in RUN.
- Grant and write are zero latency: a fire in cycle T writes the register file at the posedge ending T.
- busy updates one cycle after alloc or commit: visible in T+1.
- INIT takes exactly 31 cycles after reset release; the first RUN grant is possible in cycle 32.
- Reset asserted mid-INIT or mid-RUN: all state returns to reset values asynchronously; INIT restarts from x1.
- With both ports continuously valid, port 1 is granted no later than every STARVE_LIM+1 cycles.

## Configuration
- XC_RF_INIT_EN defined: the INIT state and init_cnt are present. The register file is zeroed after every reset, and init_done rises after 31 cycles.
- XC_RF_INIT_EN undefined: the INIT logic is removed. The block resets directly into RUN with init_done = 1, and register contents are undefined until first written.

## Test plan
- Reset with XC_RF_INIT_EN:
  - Expect rd_wen=1 with rd_addr=1..31 and rd_wdata=0 on consecutive cycles, both readies 0.
  - Expect init_done=1 at cycle 32, and a p0 write of x5=0xDEADBEEF accepted in the same cycle.
- p0 and p1 valid every cycle, STARVE_LIM=4:
  - Expect p0 granted for 4 cycles, p1 granted in cycle 5, then the pattern repeats.
  - starve_cnt is never above 4.
- p1_alloc x7 at T:
  - Expect busy[7]=1 at T+1.
  - p1 write x7=0x12345678 fires at T+3: rd_wen=1 at T+3 and busy[7]=0 at T+4.
- Same-cycle p1_alloc x9 and p1 commit x9 with busy[9] already set: busy[9] remains 1.
  - p1_alloc x0: busy stays 0.
- p0 write to x0: p0_ready=1 and rd_wen=0.
  - p1 alone valid: p1_ready=1 with no wait.
- Reset asserted at INIT cycle 10, released 2 cycles later: sequence restarts at rd_addr=1, and busy and starve_cnt are cleared.
